video_line_fetch: RTL

VIDEO_LINE_FETCH -- requirements
Module: video_line_fetch

---
 rtl/fta_pkg.sv | 28 ++
 rtl/video_line_fetch_pkg.sv | 24 ++
 rtl/edge_det.sv | 19 +
 rtl/video_fetch_rob.sv | 69 ++++++
 rtl/video_line_fetch.sv | 139 +++++++++++++
 5 files changed

// File: rtl/fta_pkg.sv
// Bus types shared by FTA initiators and targets: 128-bit command request
// and response records.
package fta_pkg;

  typedef logic [31:0] fta_address_t;
  typedef logic [7:0]  fta_tranid_t;

  typedef struct packed {
    logic [5:0]   cid;
    fta_tranid_t  tid;
    logic         cyc;
    logic         stb;
    logic         we;
    logic [15:0]  sel;
    fta_address_t padr;
    logic [127:0] data1;
  } fta_cmd_request128_t;

  typedef struct packed {
    logic [5:0]   cid;
    fta_tranid_t  tid;
    logic         stall;
    logic         ack;
    logic         err;
    logic [127:0] dat;
  } fta_cmd_response128_t;

endpackage

// File: rtl/video_line_fetch_pkg.sv
// Shared video definitions: line-fetch FSM states, fetch geometry constants
// and the line address helper.
package video_line_fetch_pkg;
  import fta_pkg::*;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } video_fetch_state_t;

  localparam int WORD_BYTES = 16;
  localparam int DATA_W     = 128;
  localparam int LINE_W     = 12;
  localparam int WPL_W      = 12;
  localparam int STRIDE_W   = 16;

  function automatic fta_address_t line_address(fta_address_t base,
                                                logic [LINE_W-1:0] line,
                                                logic [STRIDE_W-1:0] stride);
    return base + fta_address_t'(line) * fta_address_t'(stride);
  endfunction

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector for a level input; output is combinational against
// the registered previous value.
module edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) d_reg <= 1'b0;
    else        d_reg <= d;
  end

  assign rise = d & ~d_reg;

endmodule

// File: rtl/video_fetch_rob.sv
// Reorder buffer: responses land by transaction id, words leave in issue
// order from the head slot through a registered read with write bypass.
module video_fetch_rob
  import video_line_fetch_pkg::*;
#(
  parameter int MAXO = 8,
  parameter int IW   = $clog2(MAXO)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc,
  input  logic [IW-1:0]     alloc_idx,
  input  logic              wr,
  input  logic [IW-1:0]     wr_idx,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic              pop,
  output logic [MAXO-1:0]   pending,
  output logic [MAXO-1:0]   filled,
  output logic              head_vld,
  output logic [DATA_W-1:0] head_dat
);

  logic [DATA_W-1:0] mem [MAXO];
  logic [DATA_W-1:0] rd_reg;
  logic [IW-1:0]     head_reg;
  logic [IW-1:0]     head_next;

  assign head_next = pop ? head_reg + IW'(1) : head_reg;

  always_ff @(posedge clk) begin
    if (wr) mem[wr_idx] <= wr_dat;
  end

  // Read the slot that will be head next cycle; a same-cycle write to it wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_reg   <= '0;
      head_reg <= '0;
    end else begin
      head_reg <= head_next;
      if (wr && wr_idx == head_next) rd_reg <= wr_dat;
      else                           rd_reg <= mem[head_next];
    end
  end

  for (genvar gi = 0; gi < MAXO; gi++) begin : g_slot
    logic pend_reg;
    logic fill_reg;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        pend_reg <= 1'b0;
        fill_reg <= 1'b0;
      end else begin
        if (alloc && alloc_idx == IW'(gi))   pend_reg <= 1'b1;
        else if (wr && wr_idx == IW'(gi))    pend_reg <= 1'b0;
        if (wr && wr_idx == IW'(gi))         fill_reg <= 1'b1;
        else if (pop && head_reg == IW'(gi)) fill_reg <= 1'b0;
      end
    end

    assign pending[gi] = pend_reg;
    assign filled[gi]  = fill_reg;
  end

  assign head_vld = filled[head_reg];
  assign head_dat = rd_reg;

endmodule

// File: rtl/video_line_fetch.sv
// Video line fetcher: issues up to MAXO outstanding 128-bit reads per line
// and returns the words to the pixel consumer in address order.
module video_line_fetch
  import fta_pkg::*;
  import video_line_fetch_pkg::*;
#(
  parameter logic [5:0] CID  = 6'd3,
  parameter int         MAXO = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 vSync,
  input  logic                 hstart,
  input  fta_address_t         base_adr,
  input  logic [15:0]          stride,
  input  logic [11:0]          wpl,
  output fta_cmd_request128_t  req,
  input  fta_cmd_response128_t resp,
  output logic [127:0]         pix_dat,
  output logic                 pix_vld,
  input  logic                 pix_rdy,
  output logic                 busy,
  output logic                 ovr
);

  localparam int IW = $clog2(MAXO);

  video_fetch_state_t state_reg, state_next;
  logic [LINE_W-1:0]  line_reg, line_cur;
  logic               vs_pend_reg, vs_rise;
  fta_address_t       padr_reg;
  logic [IW-1:0]      tid_reg;
  logic [WPL_W-1:0]   word_reg, wpl_reg;
  logic [IW:0]        outst_reg;
  logic               ovr_reg;
  logic               start, cyc, accept, pop, resp_hit;
  logic [MAXO-1:0]    rob_pending, rob_filled;
  logic [DATA_W-1:0]  rob_wr_dat;

  edge_det u_vs_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (vSync),
    .rise (vs_rise)
  );

  assign start    = (state_reg == ST_IDLE) && hstart && en && (wpl != '0);
  assign line_cur = (vs_pend_reg || vs_rise) ? '0 : line_reg;
  assign accept   = cyc && !resp.stall;
  assign pop      = pix_vld && pix_rdy;
  // Only ids we actually issued (upper bits clear, slot awaiting data) count.
  assign resp_hit = resp.ack && (resp.cid == CID) && ((resp.tid >> IW) == '0)
                    && rob_pending[resp.tid[IW-1:0]];
  assign rob_wr_dat = resp.err ? '0 : resp.dat;

  always_comb begin
    state_next = state_reg;
    cyc        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        cyc = (outst_reg != (IW+1)'(MAXO)) && !rob_pending[tid_reg] && !rob_filled[tid_reg];
        if (cyc && !resp.stall && word_reg == wpl_reg - WPL_W'(1)) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (outst_reg == '0 && rob_pending == '0 && rob_filled == '0) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      line_reg    <= '0;
      vs_pend_reg <= 1'b0;
      padr_reg    <= '0;
      tid_reg     <= '0;
      word_reg    <= '0;
      wpl_reg     <= '0;
      outst_reg   <= '0;
      ovr_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (vs_rise) vs_pend_reg <= 1'b1;
      if (start) begin
        vs_pend_reg <= 1'b0;
        line_reg    <= line_cur + LINE_W'(1);
        padr_reg    <= line_address(base_adr, line_cur, stride);
        word_reg    <= '0;
        wpl_reg     <= wpl;
      end
      if (accept) begin
        padr_reg <= padr_reg + fta_address_t'(WORD_BYTES);
        tid_reg  <= tid_reg + IW'(1);
        word_reg <= word_reg + WPL_W'(1);
      end
      case ({accept, pop})
        2'b10:   outst_reg <= outst_reg + (IW+1)'(1);
        2'b01:   outst_reg <= outst_reg - (IW+1)'(1);
        default: outst_reg <= outst_reg;
      endcase
      if ((hstart && state_reg != ST_IDLE) || (resp_hit && resp.err)) ovr_reg <= 1'b1;
    end
  end

  video_fetch_rob #(.MAXO(MAXO)) u_rob (
    .clk      (clk),
    .rst_n    (rst_n),
    .alloc    (accept),
    .alloc_idx(tid_reg),
    .wr       (resp_hit),
    .wr_idx   (resp.tid[IW-1:0]),
    .wr_dat   (rob_wr_dat),
    .pop      (pop),
    .pending  (rob_pending),
    .filled   (rob_filled),
    .head_vld (pix_vld),
    .head_dat (pix_dat)
  );

  always_comb begin
    req      = '0;
    req.cyc  = cyc;
    req.stb  = cyc;
    req.we   = 1'b0;
    req.sel  = (state_reg == ST_ISSUE) ? '1 : '0;
    req.cid  = CID;
    req.tid  = fta_tranid_t'(tid_reg);
    req.padr = padr_reg;
  end

  assign busy = (state_reg != ST_IDLE);
  assign ovr  = ovr_reg;

endmodule
